// File: rtl/seg7_mmio_if.sv
// Request/response bus between the SoC peripheral interconnect and the
// seg7_mmio register front-end: single-beat requests, one response each.
interface seg7_mmio_if #(
    parameter int ADDR_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/seg7_mmio.sv
// Register front-end for the 7-segment display: DATA/CTRL registers, freeze
// staging and a two-state request/response FSM. SEG7_MMIO_INC_EN adds INC at 0x8.
module seg7_mmio #(
    parameter int NR_DIGIT = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_mmio_if.slave            bus,
    output logic [4*NR_DIGIT-1:0] disp_data
);
    localparam int DISP_W = 4 * NR_DIGIT;
    localparam int WORD_W = ADDR_W - 2;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t              state, state_nxt;
    logic [31:0]         shadow, shadow_nxt;
    logic [DISP_W-1:0]   shown, shown_nxt;
    logic                freeze, freeze_nxt;
    logic [31:0]         rdata, rdata_nxt;
    logic [WORD_W-1:0]   word;
    logic                accept;
    logic                unused_addr;

    assign word        = bus.req_addr[ADDR_W-1:2];
    assign unused_addr = ^bus.req_addr[1:0];
    assign accept      = (state == IDLE) && bus.req_valid;

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid)  state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shadow_nxt = shadow;
        freeze_nxt = freeze;
        rdata_nxt  = rdata;
        if (accept) begin
            rdata_nxt = '0;
            if (word == WORD_W'(0)) begin
                if (bus.req_we) begin
                    for (int k = 0; k < 4; k++)
                        if (bus.req_wstrb[k]) shadow_nxt[8*k +: 8] = bus.req_wdata[8*k +: 8];
                end else begin
                    rdata_nxt = shadow;
                end
            end else if (word == WORD_W'(1)) begin
                if (bus.req_we) freeze_nxt = bus.req_wdata[0];
                else            rdata_nxt  = {31'd0, freeze};
            end
`ifdef SEG7_MMIO_INC_EN
            else if (word == WORD_W'(2)) begin
                if (bus.req_we) shadow_nxt = shadow + bus.req_wdata;
            end
`endif
        end
        // Unfrozen after this edge means shown tracks shadow; this also covers
        // the 1->0 release copy, while a 0->1 transition leaves shown alone.
        shown_nxt = shown;
        if (!freeze_nxt) shown_nxt = shadow_nxt[DISP_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            shown  <= '0;
            freeze <= 1'b0;
            rdata  <= '0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            shown  <= shown_nxt;
            freeze <= freeze_nxt;
            rdata  <= rdata_nxt;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata;
    assign disp_data      = shown;
endmodule

// File: tb/tb_seg7_mmio.sv
// Directed self-checking bench for seg7_mmio; an NR_DIGIT=4 copy runs in
// lockstep on the same bus traffic to check digit truncation.
module tb_seg7_mmio;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] disp_data;
    logic [15:0] disp4;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;
    logic [31:0] disp_at_resp;
    logic [15:0] disp4_at_resp;

    always #5 clk = ~clk;

    seg7_mmio_if #(.ADDR_W(4)) bus ();
    seg7_mmio_if #(.ADDR_W(4)) bus4 ();

    assign bus4.req_valid  = bus.req_valid;
    assign bus4.req_we     = bus.req_we;
    assign bus4.req_addr   = bus.req_addr;
    assign bus4.req_wdata  = bus.req_wdata;
    assign bus4.req_wstrb  = bus.req_wstrb;
    assign bus4.resp_ready = bus.resp_ready;

    seg7_mmio #(.NR_DIGIT(8), .ADDR_W(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .disp_data (disp_data)
    );

    seg7_mmio #(.NR_DIGIT(4), .ADDR_W(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus4.slave),
        .disp_data (disp4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transaction; leaves rdata and the display seen one cycle after accept.
    task automatic xact(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata);
        int n;
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check("ready_timeout", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("resp_valid", 32'(bus.resp_valid), 32'd1);
        rdata         = bus.resp_rdata;
        disp_at_resp  = disp_data;
        disp4_at_resp = disp4;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wstrb  = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        rst_n = 1'b1;
        check("rst_disp", disp_data, 32'd0);
        check("rst_disp4", 32'(disp4), 32'd0);

        xact(1'b0, 4'h0, 32'd0, 4'h0, rd);
        check("rd_data_rst", rd, 32'd0);
        xact(1'b0, 4'h4, 32'd0, 4'h0, rd);
        check("rd_ctrl_rst", rd, 32'd0);

        xact(1'b1, 4'h0, 32'h1234_5678, 4'hF, rd);
        check("wr_resp_zero", rd, 32'd0);
        check("wr_full_disp", disp_at_resp, 32'h1234_5678);
        check("wr_full_disp4", 32'(disp4_at_resp), 32'h5678);
        xact(1'b1, 4'h0, 32'hAB00_0000, 4'h8, rd);
        check("wr_lane3_disp", disp_at_resp, 32'hAB34_5678);
        xact(1'b1, 4'h0, 32'hFFFF_FF99, 4'h1, rd);
        check("wr_lane0_disp", disp_at_resp, 32'hAB34_5699);
        xact(1'b1, 4'h0, 32'h0000_0078, 4'h1, rd);
        xact(1'b0, 4'h0, 32'd0, 4'h0, rd);
        check("rd_data_partial", rd, 32'hAB34_5678);

        xact(1'b1, 4'h4, 32'hFFFF_FFFF, 4'h0, rd);
        xact(1'b0, 4'h4, 32'd0, 4'h0, rd);
        check("rd_ctrl_frozen", rd, 32'd1);
        xact(1'b1, 4'h0, 32'hCAFE_BABE, 4'hF, rd);
        check("frozen_disp", disp_at_resp, 32'hAB34_5678);
        check("frozen_disp4", 32'(disp4_at_resp), 32'h5678);
        xact(1'b0, 4'h0, 32'd0, 4'h0, rd);
        check("frozen_rd_data", rd, 32'hCAFE_BABE);
        xact(1'b1, 4'h4, 32'd0, 4'h0, rd);
        check("unfreeze_disp", disp_at_resp, 32'hCAFE_BABE);
        check("unfreeze_disp4", 32'(disp4_at_resp), 32'hBABE);

        xact(1'b1, 4'h0, 32'hFFFF_FFFE, 4'hF, rd);
`ifdef SEG7_MMIO_INC_EN
        xact(1'b1, 4'h8, 32'd1, 4'h0, rd);
        check("inc1_disp", disp_at_resp, 32'hFFFF_FFFF);
        xact(1'b1, 4'h8, 32'd1, 4'h0, rd);
        check("inc_wrap_disp", disp_at_resp, 32'h0000_0000);
        xact(1'b0, 4'h8, 32'd0, 4'h0, rd);
        check("rd_inc_zero", rd, 32'd0);
        xact(1'b1, 4'h0, 32'h0000_0001, 4'hF, rd);
        xact(1'b1, 4'h8, 32'hFFFF_FFFF, 4'h0, rd);
        check("inc_max_disp", disp_at_resp, 32'h0000_0000);
`else
        xact(1'b1, 4'h8, 32'd1, 4'h0, rd);
        check("inc_off_disp", disp_at_resp, 32'hFFFF_FFFE);
        xact(1'b0, 4'h8, 32'd0, 4'h0, rd);
        check("rd_inc_off", rd, 32'd0);
        xact(1'b0, 4'h0, 32'd0, 4'h0, rd);
        check("inc_off_data", rd, 32'hFFFF_FFFE);
`endif

        xact(1'b1, 4'h0, 32'h89AB_CDEF, 4'hF, rd);
        check("nr4_disp", disp_at_resp, 32'h89AB_CDEF);
        check("nr4_disp4", 32'(disp4_at_resp), 32'hCDEF);
        xact(1'b1, 4'hC, 32'hDEAD_BEEF, 4'hF, rd);
        check("unmapped_wr_disp", disp_at_resp, 32'h89AB_CDEF);
        xact(1'b0, 4'hC, 32'd0, 4'h0, rd);
        check("unmapped_rd", rd, 32'd0);
        xact(1'b0, 4'h0, 32'd0, 4'h0, rd);
        check("unmapped_data", rd, 32'h89AB_CDEF);

        // Back-pressure: response held, a second request waits and is never taken.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 4'h0;
        @(negedge clk);
        bus.req_we    = 1'b1;
        bus.req_wdata = 32'h1111_1111;
        bus.req_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("stall_rdata", bus.resp_rdata, 32'h89AB_CDEF);
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        check("stall_disp", disp_data, 32'h89AB_CDEF);
        bus.req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("async_req_ready", 32'(bus.req_ready), 32'd1);
        check("async_disp", disp_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        xact(1'b0, 4'h0, 32'd0, 4'h0, rd);
        check("post_rst_data", rd, 32'd0);
        xact(1'b0, 4'h4, 32'd0, 4'h0, rd);
        check("post_rst_ctrl", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
